// File: rtl/em_port_arbiter.sv
// em_port_arbiter: two-requester round-robin arbiter and sequencer for the
// shared data port of the external byte-addressed memory (EM).
//   requester 0 = CPU data path, requester 1 = loader/DMA path.
// Each access runs IDLE (grant) -> ISSUE (EM strobe) -> DONE (done pulse).
// Optional build macro: BOUNDS_CHECK_EN
//   defined   : accesses touching a byte >= MEM_SIZE are suppressed and flagged
//   undefined : no check, err outputs stay 0
module em_port_arbiter #(
  parameter int MEM_SIZE = 125,
  parameter int AW       = 10
) (
  input  logic            clock,
  input  logic            reset,
  // requester 0 (CPU)
  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [1:0]      r0_size,
  input  logic [AW-1:0]   r0_addr,
  input  logic [31:0]     r0_wdata,
  output logic            r0_gnt,
  output logic            r0_done,
  output logic [31:0]     r0_rdata,
  output logic            r0_err,
  // requester 1 (loader/DMA)
  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [1:0]      r1_size,
  input  logic [AW-1:0]   r1_addr,
  input  logic [31:0]     r1_wdata,
  output logic            r1_gnt,
  output logic            r1_done,
  output logic [31:0]     r1_rdata,
  output logic            r1_err,
  // EM port
  output logic [2:0]      em_control,
  output logic [4*AW-1:0] em_address,
  output logic [31:0]     em_wdata,
  input  logic [31:0]     em_read
);

`ifdef BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  // Highest legal byte index + 1, in the unwrapped AW+1-bit domain.
  localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Size code 0 is an alias for a full word.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    logic [1:0] res;
    case (size)
      2'd0:    res = 2'd3;
      default: res = size;
    endcase
    return res;
  endfunction

  // Offset of the last byte touched: writes cover only their size, reads
  // always fetch all four lanes.
  function automatic logic [1:0] last_offset(input logic we, input logic [1:0] size_e);
    logic [1:0] res;
    if (we) begin
      case (size_e)
        2'd1:    res = 2'd0;
        2'd2:    res = 2'd1;
        default: res = 2'd3;
      endcase
    end else begin
      res = 2'd3;
    end
    return res;
  endfunction

  // State and datapath registers
  state_t          state_q, state_d;
  logic            rr_q, rr_d;          // 1: requester 1 wins a tie
  logic            sel_q, sel_d;        // requester owning the current access
  logic            err_q, err_d;        // current access is out of range
  logic [2:0]      em_control_q, em_control_d;
  logic [4*AW-1:0] em_address_q, em_address_d;
  logic [31:0]     em_wdata_q, em_wdata_d;
  logic [31:0]     r0_rdata_q, r0_rdata_d;
  logic [31:0]     r1_rdata_q, r1_rdata_d;
  logic            r0_done_q, r0_done_d;
  logic            r1_done_q, r1_done_d;
  logic            r0_err_q, r0_err_d;
  logic            r1_err_q, r1_err_d;

  // Arbitration and selected-request signals
  logic            req_any_s;
  logic            grant_sel_s;
  logic            gnt_s;
  logic            sel_we_s;
  logic [1:0]      sel_size_s;
  logic [1:0]      size_eff_s;
  logic [AW-1:0]   sel_addr_s;
  logic [31:0]     sel_wdata_s;
  logic [1:0]      span_s;
  logic [AW:0]     last_byte_s;
  logic            oob_s;
  logic [4*AW-1:0] lanes_s;

  // Pick the winning requester: a lone requester always wins, a tie goes
  // to whoever was not granted last.
  always_comb begin
    req_any_s   = r0_req | r1_req;
    grant_sel_s = 1'b0;
    if (r0_req && r1_req) begin
      grant_sel_s = rr_q;
    end else if (r1_req) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
  end

  assign gnt_s  = (state_q == ST_IDLE) && req_any_s;
  assign r0_gnt = gnt_s & ~grant_sel_s;
  assign r1_gnt = gnt_s &  grant_sel_s;

  // Route the winner's request fields and derive lane addresses and range.
  always_comb begin
    if (grant_sel_s) begin
      sel_we_s    = r1_we;
      sel_size_s  = r1_size;
      sel_addr_s  = r1_addr;
      sel_wdata_s = r1_wdata;
    end else begin
      sel_we_s    = r0_we;
      sel_size_s  = r0_size;
      sel_addr_s  = r0_addr;
      sel_wdata_s = r0_wdata;
    end
    size_eff_s  = eff_size(sel_size_s);
    span_s      = last_offset(sel_we_s, size_eff_s);
    // Unwrapped sum so an access running past 2^AW still counts as out of range.
    last_byte_s = {1'b0, sel_addr_s} + {{(AW-1){1'b0}}, span_s};
    oob_s       = CHECK_EN & (last_byte_s >= MEM_LIMIT);
    // Lane addresses wrap modulo 2^AW.
    lanes_s     = {sel_addr_s + AW'(3), sel_addr_s + AW'(2),
                   sel_addr_s + AW'(1), sel_addr_s};
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    err_d        = err_q;
    em_control_d = em_control_q;
    em_address_d = em_address_q;
    em_wdata_d   = em_wdata_q;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;
    r0_done_d    = 1'b0;
    r1_done_d    = 1'b0;
    r0_err_d     = 1'b0;
    r1_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          sel_d        = grant_sel_s;
          rr_d         = ~grant_sel_s;
          err_d        = oob_s;
          em_address_d = lanes_s;
          em_wdata_d   = sel_wdata_s;
          if (sel_we_s && !oob_s) begin
            em_control_d = {1'b0, size_eff_s};
          end else begin
            em_control_d = 3'd0;
          end
          state_d = ST_ISSUE;
        end else begin
          em_control_d = 3'd0;
          state_d      = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // EM write happens on this closing edge; em_read still shows the
        // pre-write contents, which is what the requester gets back.
        em_control_d = 3'd0;
        if (sel_q) begin
          r1_rdata_d = err_q ? 32'd0 : em_read;
          r1_done_d  = 1'b1;
          r1_err_d   = err_q;
        end else begin
          r0_rdata_d = err_q ? 32'd0 : em_read;
          r0_done_d  = 1'b1;
          r0_err_d   = err_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        em_control_d = 3'd0;
        state_d      = ST_IDLE;
      end
      default: begin
        em_control_d = 3'd0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      sel_q        <= 1'b0;
      err_q        <= 1'b0;
      em_control_q <= 3'd0;
      em_address_q <= '0;
      em_wdata_q   <= 32'd0;
      r0_rdata_q   <= 32'd0;
      r1_rdata_q   <= 32'd0;
      r0_done_q    <= 1'b0;
      r1_done_q    <= 1'b0;
      r0_err_q     <= 1'b0;
      r1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      em_control_q <= em_control_d;
      em_address_q <= em_address_d;
      em_wdata_q   <= em_wdata_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
      r0_done_q    <= r0_done_d;
      r1_done_q    <= r1_done_d;
      r0_err_q     <= r0_err_d;
      r1_err_q     <= r1_err_d;
    end
  end

  assign em_control = em_control_q;
  assign em_address = em_address_q;
  assign em_wdata   = em_wdata_q;
  assign r0_rdata   = r0_rdata_q;
  assign r1_rdata   = r1_rdata_q;
  assign r0_done    = r0_done_q;
  assign r1_done    = r1_done_q;
  assign r0_err     = r0_err_q;
  assign r1_err     = r1_err_q;

endmodule
